program_loader: RTL and testbench

Boot-time instruction loader placed upstream of the pipelined processor. Accepts a byte stream carrying a length header, 19-bit instruction words and a checksum, and writes the words into instruction memory from address 0. Holds the processor in reset until a load completes with a valid checksum, then releases it.

---
 rtl/program_loader_pkg.sv | 30 +++
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader_word_assembler.sv | 31 +++
 rtl/program_loader.sv | 141 ++++++++++++++
 tb/tb_program_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    localparam int WORD_W         = 19;
    localparam int ADDR_W_DEFAULT = 12;
    localparam int CSUM_W         = 8;
    localparam int LEN_W          = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        W0,
        W1,
        W2,
        WRITE,
        CSUM,
        RUN,
        ERR
    } loader_state_t;

    function automatic logic accepts_bytes(loader_state_t s);
        return s inside {LEN_HI, LEN_LO, W0, W1, W2, CSUM};
    endfunction

    function automatic logic is_loading(loader_state_t s);
        return s inside {LEN_HI, LEN_LO, W0, W1, W2, WRITE, CSUM};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Builds a 24-bit big-endian word from three stream bytes and flags nonzero padding.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ok
);
    logic [7:0]  hi_reg;
    logic [7:0]  mid_reg;
    logic [23:0] raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg  <= '0;
            mid_reg <= '0;
        end else if (shift_en) begin
            hi_reg  <= mid_reg;
            mid_reg <= byte_in;
        end
    end

    // The third byte is taken live so the word is complete in the W2 transfer cycle.
    assign raw     = {hi_reg, mid_reg, byte_in};
    assign word    = raw[WORD_W-1:0];
    assign word_ok = (raw[23:WORD_W] == '0);

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses length/words/checksum stream, writes instruction memory, gates cpu_reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    program_loader_if.master  bus,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    loader_state_t      state_reg;
    loader_state_t      state_next;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   len_rx;
    logic [LEN_W:0]     word_cnt_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [CSUM_W-1:0]  csum_reg;
    logic               pad_err_reg;
    logic               byte_ready_reg;
    logic               imem_we_reg;
    logic [WORD_W-1:0]  imem_wdata_reg;
    logic               cpu_reset_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;
    logic               xfer;
    logic               last_word;
    logic               asm_shift;
    logic [WORD_W-1:0]  asm_word;
    logic               asm_word_ok;

    assign xfer      = bus.byte_valid & byte_ready_reg;
    assign len_rx    = {len_reg[LEN_W-1:8], bus.byte_data};
    assign last_word = ({1'b0, len_reg} == (word_cnt_reg + 1'b1));
    assign asm_shift = xfer && (state_reg == W0 || state_reg == W1);

    word_assembler u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .shift_en (asm_shift),
        .byte_in  (bus.byte_data),
        .word     (asm_word),
        .word_ok  (asm_word_ok)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, RUN, ERR: if (start) state_next = LEN_HI;
            LEN_HI:         if (xfer) state_next = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_rx == '0)                 state_next = CSUM;
                    else if ({1'b0, len_rx} > CAPACITY) state_next = ERR;
                    else                              state_next = W0;
                end
            end
            W0:    if (xfer) state_next = W1;
            W1:    if (xfer) state_next = W2;
            W2:    if (xfer) state_next = WRITE;
            WRITE: begin
                if (pad_err_reg)    state_next = ERR;
                else if (last_word) state_next = CSUM;
                else                state_next = W0;
            end
            CSUM: begin
                if (xfer) state_next = (csum_reg == bus.byte_data) ? RUN : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            word_cnt_reg   <= '0;
            addr_reg       <= '0;
            csum_reg       <= '0;
            pad_err_reg    <= 1'b0;
            byte_ready_reg <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_wdata_reg <= '0;
            cpu_reset_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_ready_reg <= accepts_bytes(state_next);
            busy_reg       <= is_loading(state_next);
            done_reg       <= (state_next == RUN);
            error_reg      <= (state_next == ERR);
            cpu_reset_reg  <= (state_next != RUN);
            imem_we_reg    <= 1'b0;

            if (state_next == LEN_HI && state_reg != LEN_HI) begin
                word_cnt_reg <= '0;
                addr_reg     <= '0;
                csum_reg     <= '0;
                pad_err_reg  <= 1'b0;
            end

            if (xfer && state_reg != CSUM) begin
                csum_reg <= csum_reg ^ bus.byte_data;
            end

            if (xfer && state_reg == LEN_HI) len_reg[LEN_W-1:8] <= bus.byte_data;
            if (xfer && state_reg == LEN_LO) len_reg[7:0]       <= bus.byte_data;

            if (xfer && state_reg == W2) begin
                imem_we_reg    <= asm_word_ok;
                imem_wdata_reg <= asm_word;
                pad_err_reg    <= ~asm_word_ok;
            end

            if (state_reg == WRITE && !pad_err_reg) begin
                addr_reg     <= addr_reg + 1'b1;
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.byte_ready = byte_ready_reg;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign cpu_reset      = cpu_reset_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stream vectors table plus multi-cycle corner sequences.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_reset;
    logic busy;
    logic done;
    logic error;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0]     wa_q[$];
    logic [WORD_W-1:0] wd_q[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    typedef struct {
        string             name;
        logic [7:0]        b[12];
        int                nb;
        logic [WORD_W-1:0] w[3];
        int                nw;
        bit                ok;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 16 && !ok; t++) begin
            if (bus.byte_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    // byte_valid is held high during the start cycle: it must not count as a transfer.
    task automatic pulse_start();
        start          = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        @(negedge clk);
        start          = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input logic [WORD_W-1:0] words[$]);
        check({name, ".nwrites"}, 32'(wa_q.size()), 32'(words.size()));
        for (int i = 0; i < words.size(); i++) begin
            if (i < wa_q.size()) begin
                check({name, ".addr"}, 32'(wa_q[i]), 32'(i));
                check({name, ".data"}, 32'(wd_q[i]), 32'(words[i]));
            end
        end
    endtask

    task automatic run_stream(input string name, input logic [7:0] bytes[$],
                              input logic [WORD_W-1:0] words[$], input bit ok);
        bit acc;
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        check({name, ".busy_after_start"}, 32'(busy), 32'd1);
        check({name, ".cpu_reset_after_start"}, 32'(cpu_reset), 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], acc);
            check({name, ".byte_accepted"}, 32'(acc), 32'd1);
            if (!acc) break;
        end
        if (ok) begin
            check({name, ".done"}, 32'(done), 32'd1);
            check({name, ".cpu_reset"}, 32'(cpu_reset), 32'd0);
            check({name, ".busy"}, 32'(busy), 32'd0);
        end else begin
            repeat (4) @(negedge clk);
            check({name, ".error"}, 32'(error), 32'd1);
            check({name, ".done"}, 32'(done), 32'd0);
            check({name, ".cpu_reset"}, 32'(cpu_reset), 32'd1);
            check({name, ".byte_ready"}, 32'(bus.byte_ready), 32'd0);
        end
        check_writes(name, words);
        $display("stream %s: bytes=%0d writes=%0d done=%b error=%b cpu_reset=%b",
                 name, bytes.size(), wa_q.size(), done, error, cpu_reset);
    endtask

    initial begin
        logic [7:0]        bq[$];
        logic [WORD_W-1:0] wq[$];
        logic [7:0]        good3[12];
        logic [7:0]        cs;
        logic [23:0]       w24;
        bit                acc;

        vecs[0].name = "good3";
        vecs[0].b    = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h23, 8'h07, 8'hFF, 8'hFF,
                         8'h01, 8'h00, 8'h00, 8'h27};
        vecs[0].nb = 12; vecs[0].w = '{19'h00123, 19'h7FFFF, 19'h10000}; vecs[0].nw = 3; vecs[0].ok = 1;
        vecs[1].name = "zero_len";
        vecs[1].b    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nb = 3; vecs[1].w = '{19'h0, 19'h0, 19'h0}; vecs[1].nw = 0; vecs[1].ok = 1;
        vecs[2].name = "bad_csum";
        vecs[2].b    = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h23, 8'h07, 8'hFF, 8'hFF,
                         8'h01, 8'h00, 8'h00, 8'h05};
        vecs[2].nb = 12; vecs[2].w = '{19'h00123, 19'h7FFFF, 19'h10000}; vecs[2].nw = 3; vecs[2].ok = 0;
        vecs[3].name = "padding";
        vecs[3].b    = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].nb = 8; vecs[3].w = '{19'h00005, 19'h0, 19'h0}; vecs[3].nw = 1; vecs[3].ok = 0;
        vecs[4].name = "oversize";
        vecs[4].b    = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].nb = 2; vecs[4].w = '{19'h0, 19'h0, 19'h0}; vecs[4].nw = 0; vecs[4].ok = 0;
        vecs[5].name = "zero_bad_csum";
        vecs[5].b    = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5].nb = 3; vecs[5].w = '{19'h0, 19'h0, 19'h0}; vecs[5].nw = 0; vecs[5].ok = 0;
        good3 = vecs[0].b;

        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst.byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst.imem_we", 32'(bus.imem_we), 32'd0);
        check("rst.imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst.imem_wdata", 32'(bus.imem_wdata), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle.byte_ready", 32'(bus.byte_ready), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            bq.delete();
            wq.delete();
            for (int i = 0; i < vecs[v].nb; i++) bq.push_back(vecs[v].b[i]);
            for (int i = 0; i < vecs[v].nw; i++) wq.push_back(vecs[v].w[i]);
            run_stream(vecs[v].name, bq, wq, vecs[v].ok);
        end

        // Reset while in W1 of word 2, with exact write timing checked on word 1.
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            send_byte(good3[k], acc);
            check("midrst.byte_accepted", 32'(acc), 32'd1);
            if (k == 4) begin
                check("midrst.we_after_w2", 32'(bus.imem_we), 32'd1);
                check("midrst.addr_after_w2", 32'(bus.imem_addr), 32'd0);
                check("midrst.data_after_w2", 32'(bus.imem_wdata), 32'h00123);
                check("midrst.ready_in_write", 32'(bus.byte_ready), 32'd0);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.byte_ready", 32'(bus.byte_ready), 32'd0);
        check("midrst.cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.error", 32'(error), 32'd0);
        $display("sequence mid_reset: writes_before_reset=%0d busy=%b cpu_reset=%b",
                 wa_q.size(), busy, cpu_reset);

        // Fresh load after reset, with a stalled source and a start pulse while busy.
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            send_byte(good3[k], acc);
            check("reload.byte_accepted", 32'(acc), 32'd1);
            if (k == 6) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                check("reload.busy_after_start_ignored", 32'(busy), 32'd1);
            end
        end
        check("reload.done", 32'(done), 32'd1);
        check("reload.cpu_reset", 32'(cpu_reset), 32'd0);
        wq.delete();
        wq.push_back(19'h00123);
        wq.push_back(19'h7FFFF);
        wq.push_back(19'h10000);
        check_writes("reload", wq);
        $display("sequence reload: writes=%0d done=%b cpu_reset=%b", wa_q.size(), done, cpu_reset);

        // Exactly full memory: 16 words into a 16-entry space.
        bq.delete();
        wq.delete();
        bq.push_back(8'h00);
        bq.push_back(8'h10);
        cs = 8'h10;
        for (int i = 0; i < 16; i++) begin
            w24 = (24'(i) * 24'h012345) & 24'h07FFFF;
            wq.push_back(w24[WORD_W-1:0]);
            bq.push_back(w24[23:16]);
            bq.push_back(w24[15:8]);
            bq.push_back(w24[7:0]);
            cs = cs ^ w24[23:16] ^ w24[15:8] ^ w24[7:0];
        end
        bq.push_back(cs);
        run_stream("full16", bq, wq, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
